// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle sequencer: decoder control
// bundle, FSM state encoding and the RISC-V major opcodes the sequencer inspects.
package multicycle_ctrl_pkg;

  typedef struct packed {
    logic       reg_wr_en;
    logic       mem_wr_en;
    logic [3:0] mem_byt_en;
  } t_ctrl;

  typedef logic [3:0] t_mc_state;

  localparam t_mc_state ST_IDLE   = 4'd0;
  localparam t_mc_state ST_FETCH  = 4'd1;
  localparam t_mc_state ST_WAIT_I = 4'd2;
  localparam t_mc_state ST_DECODE = 4'd3;
  localparam t_mc_state ST_EXEC   = 4'd4;
  localparam t_mc_state ST_MEM    = 4'd5;
  localparam t_mc_state ST_WAIT_D = 4'd6;
  localparam t_mc_state ST_WB     = 4'd7;
  localparam t_mc_state ST_HALT   = 4'd8;
  localparam t_mc_state ST_FAULT  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic is_mem_access(t_ctrl c);
    return c.mem_byt_en != 4'b0000;
  endfunction

endpackage

// File: rtl/mc_timeout_cnt.sv
// Memory-wait watchdog: down-counter reloaded on clear, terminal count at zero.
// expired is only meaningful while enable is high.
module mc_timeout_cnt #(
  parameter int unsigned MEM_TIMEOUT = 255,
  localparam int unsigned W = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] LOAD = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = LOAD;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= LOAD;
    else     cnt_q <= cnt_d;
  end

  assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer with memory watchdog.
// Define MC_PERF_CNT_EN to build the cycle and retired-instruction counters.
//
// state  | meaning
// IDLE   | one cycle after reset before the first fetch
// FETCH  | imem_req held until imem_gnt
// WAIT_I | waiting for imem_rvalid, loads instr
// DECODE | decoder output settles
// EXEC   | execute; picks MEM or WB
// MEM    | dmem_req held until dmem_gnt
// WAIT_D | waiting for load data
// WB     | pc_en and register write strobe
// HALT   | SYSTEM retired, absorbing
// FAULT  | memory timeout, absorbing
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  input  t_ctrl            ctrl,
  input  logic [4:0]       rd,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  output logic             rf_wr_en,
  output logic             pc_en,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  t_mc_state   state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        tmo_en, tmo_expired;

  assign tmo_en = (state_q == ST_FETCH) || (state_q == ST_WAIT_I) ||
                  (state_q == ST_MEM)   || (state_q == ST_WAIT_D);

  mc_timeout_cnt #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_d != state_q),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  // A grant or response in the final watchdog cycle still wins over the fault.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_gnt)         state_d = ST_WAIT_I;
        else if (tmo_expired) state_d = ST_FAULT;
      end
      ST_WAIT_I: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = ST_DECODE;
        end else if (tmo_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = is_mem_access(ctrl) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (dmem_gnt)         state_d = ctrl.mem_wr_en ? ST_WB : ST_WAIT_D;
        else if (tmo_expired) state_d = ST_FAULT;
      end
      ST_WAIT_D: begin
        if (dmem_rvalid)      state_d = ST_WB;
        else if (tmo_expired) state_d = ST_FAULT;
      end
      ST_WB:     state_d = (instr_q[6:0] == OPC_SYSTEM) ? ST_HALT : ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  assign instr    = instr_q;
  assign imem_req = (state_q == ST_FETCH);
  assign dmem_req = (state_q == ST_MEM);
  assign dmem_we  = (state_q == ST_MEM) && ctrl.mem_wr_en;
  assign pc_en    = (state_q == ST_WB);
  assign rf_wr_en = (state_q == ST_WB) && ctrl.reg_wr_en && (rd != 5'd0) &&
                    (instr_q[6:0] != OPC_SYSTEM);
  assign halted   = (state_q == ST_HALT);
  assign fault    = (state_q == ST_FAULT);

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (state_q == ST_WB) instret_cnt_q <= instret_cnt_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a transaction-level planner expands each
// instruction and its memory latencies into the per-cycle trace the outputs must follow.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int unsigned MT = 8;
`ifdef MC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk, rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata, instr;
  t_ctrl       ctrl;
  logic [4:0]  rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic        rf_wr_en, pc_en, halted, fault;
  logic [31:0] cycle_cnt, instret_cnt;

  multicycle_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr(instr), .ctrl(ctrl), .rd(rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .rf_wr_en(rf_wr_en), .pc_en(pc_en),
    .halted(halted), .fault(fault), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Stand-in for the combinational decoder.
  function automatic t_ctrl dec(logic [31:0] w);
    t_ctrl c;
    c = '0;
    case (w[6:0])
      OPC_OP, OPC_OP_IMM: c.reg_wr_en = 1'b1;
      OPC_LOAD: begin
        c.reg_wr_en  = 1'b1;
        c.mem_byt_en = 4'b1111;
      end
      OPC_STORE: begin
        c.mem_wr_en  = 1'b1;
        c.mem_byt_en = (w[14:12] == 3'd0) ? 4'b0001 :
                       (w[14:12] == 3'd1) ? 4'b0011 : 4'b1111;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    ctrl = dec(instr);
    rd   = instr[11:7];
  end

  typedef struct packed {
    logic        chk, rst, ig, irv, dg, drv;
    logic [31:0] ird;
    logic        e_ireq, e_dreq, e_dwe, e_rf, e_pc, e_halt, e_fault;
    logic [31:0] e_instr;
  } cyc_t;

  cyc_t        q[$];
  logic [31:0] cur_instr;
  logic        st_halt, st_fault;
  int          n_cmp, n_bad, cyc;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic coin();
    return ($urandom_range(0, 3) == 0);
  endfunction

  function automatic cyc_t blank(bit ngi, bit nri, bit ngd, bit nrd);
    cyc_t c;
    c = '0;
    c.chk     = 1'b1;
    c.e_instr = cur_instr;
    c.e_halt  = st_halt;
    c.e_fault = st_fault;
    if (ngi) c.ig = coin();
    if (nri) begin
      c.irv = coin();
      c.ird = $urandom;
    end
    if (ngd) c.dg = coin();
    if (nrd) c.drv = coin();
    return c;
  endfunction

  task automatic hold(int n);
    for (int k = 0; k < n; k++) q.push_back(blank(1, 1, 1, 1));
  endtask

  // Reset starts in the last planned cycle and lasts n cycles, then one IDLE cycle.
  task automatic do_reset(int n);
    q[q.size()-1].rst = 1'b1;
    cur_instr = '0;
    st_halt   = 1'b0;
    st_fault  = 1'b0;
    for (int k = 0; k < n - 1; k++) begin
      cyc_t c;
      c = blank(1, 1, 1, 1);
      c.rst = 1'b1;
      q.push_back(c);
    end
    q.push_back(blank(1, 1, 1, 1));
  endtask

  task automatic gen_instr(logic [31:0] w, int g, int r, int dgd, int drd, bit abort_d,
                           output int ncyc);
    t_ctrl c_;
    cyc_t  c;
    int    s;
    bit    mem, ld;
    s   = q.size();
    c_  = dec(w);
    mem = (c_.mem_byt_en != 4'b0000);
    ld  = mem && !c_.mem_wr_en;
    for (int k = 0; k <= g; k++) begin
      c = blank(0, 0, 1, 1);
      c.e_ireq = 1'b1;
      if (k == g) begin
        c.ig  = 1'b1;
        c.irv = coin();
        c.ird = $urandom;
      end
      q.push_back(c);
    end
    for (int k = 0; k <= r; k++) begin
      c = blank(1, 0, 1, 1);
      if (k == r) begin
        c.irv = 1'b1;
        c.ird = w;
      end
      q.push_back(c);
    end
    cur_instr = w;
    q.push_back(blank(1, 1, 1, 1));
    q.push_back(blank(1, 1, 1, 1));
    if (mem) begin
      for (int k = 0; k <= dgd; k++) begin
        c = blank(1, 1, 0, 1);
        c.e_dreq = 1'b1;
        c.e_dwe  = c_.mem_wr_en;
        if (k == dgd) c.dg = 1'b1;
        q.push_back(c);
      end
      if (ld) begin
        for (int k = 0; k <= drd; k++) begin
          c = blank(1, 1, 1, 0);
          if (abort_d) begin
            q.push_back(c);
            ncyc = q.size() - s;
            return;
          end
          if (k == drd) c.drv = 1'b1;
          q.push_back(c);
        end
      end
    end
    c = blank(1, 1, 1, 1);
    c.e_pc = 1'b1;
    c.e_rf = c_.reg_wr_en && (w[11:7] != 5'd0) && (w[6:0] != OPC_SYSTEM);
    q.push_back(c);
    if (w[6:0] == OPC_SYSTEM) st_halt = 1'b1;
    ncyc = q.size() - s;
  endtask

  task automatic gen_rand();
    logic [6:0]  opcs [5];
    logic [31:0] w;
    int          n;
    opcs = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, 7'b1010101};
    w = $urandom;
    w[6:0] = opcs[$urandom_range(0, 4)];
    gen_instr(w, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), 1'b0, n);
  endtask

  task automatic build();
    cyc_t c;
    int   n, rel;
    cur_instr = '0;
    st_halt   = 1'b0;
    st_fault  = 1'b0;
    c = '0;
    q.push_back(c);
    do_reset(3);
    rel = q.size() - 1;
    gen_instr(32'h00500093, 0, 0, 0, 0, 1'b0, n);
    chk("plan_fetch_cycle", 32'(rel + 1), 32'(rel + 1));
    chk("plan_alu_latency", 32'(n), 32'd5);
    chk("plan_addi_rf", 32'(q[q.size()-1].e_rf), 32'd1);
    gen_instr(32'h00208033, 0, 0, 0, 0, 1'b0, n);
    chk("plan_add_x0_rf", 32'(q[q.size()-1].e_rf), 32'd0);
    gen_instr(32'h0020A223, 0, 0, 3, 0, 1'b0, n);
    chk("plan_store_gnt3", 32'(n), 32'd9);
    gen_instr(32'h0020A223, 0, 0, 0, 0, 1'b0, n);
    chk("plan_store_latency", 32'(n), 32'd6);
    gen_instr(32'h0000A183, 0, 0, 0, 0, 1'b0, n);
    chk("plan_load_latency", 32'(n), 32'd7);
    for (int i = 0; i < 25; i++) gen_rand();
    gen_instr(32'h00000073, 0, 0, 0, 0, 1'b0, n);
    hold(8);

    do_reset(3);
    n = q.size();
    for (int k = 0; k < int'(MT); k++) begin
      c = blank(0, 0, 1, 1);
      c.e_ireq = 1'b1;
      q.push_back(c);
    end
    chk("plan_timeout_fetch", 32'(q.size() - n), 32'd8);
    st_fault = 1'b1;
    hold(10);

    do_reset(3);
    gen_rand();
    gen_instr(32'h0000A183, 1, 2, 1, 3, 1'b1, n);
    do_reset(3);
    for (int i = 0; i < 6; i++) gen_rand();
    gen_instr(32'h00000073, 2, 1, 0, 0, 1'b0, n);
    hold(5);
  endtask

  initial begin
    logic [31:0] m_cyc, m_ret;
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    m_cyc = '0; m_ret = '0;
    build();
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      cyc = i;
      if (q[i].chk) begin
        chk("imem_req", 32'(imem_req), 32'(q[i].e_ireq));
        chk("dmem_req", 32'(dmem_req), 32'(q[i].e_dreq));
        chk("dmem_we", 32'(dmem_we), 32'(q[i].e_dwe));
        chk("rf_wr_en", 32'(rf_wr_en), 32'(q[i].e_rf));
        chk("pc_en", 32'(pc_en), 32'(q[i].e_pc));
        chk("halted", 32'(halted), 32'(q[i].e_halt));
        chk("fault", 32'(fault), 32'(q[i].e_fault));
        chk("instr", instr, q[i].e_instr);
        chk("cycle_cnt", cycle_cnt, PERF ? m_cyc : 32'd0);
        chk("instret_cnt", instret_cnt, PERF ? m_ret : 32'd0);
      end
      if (q[i].rst) begin
        m_cyc = '0;
        m_ret = '0;
      end else begin
        m_cyc = m_cyc + 32'd1;
        if (q[i].e_pc) m_ret = m_ret + 32'd1;
      end
      rst         = q[i].rst;
      imem_gnt    = q[i].ig;
      imem_rvalid = q[i].irv;
      imem_rdata  = q[i].ird;
      dmem_gnt    = q[i].dg;
      dmem_rvalid = q[i].drv;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
